// File: rtl/banco_write_arbiter.sv
// banco_write_arbiter
// Round-robin arbiter that maps up to two writeback requests per cycle onto
// the register bank's C and V write ports. The two grants always target
// different registers. Granted writes are registered onto the bank ports
// one cycle later. Grants (req_ready) are combinational.
module banco_write_arbiter #(
  parameter int N_REQ  = 4,
  parameter int DATA_W = 32,
  parameter int ADDR_W = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      stall,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*ADDR_W-1:0]   req_dir,
  input  logic [N_REQ*DATA_W-1:0]   req_din,
  output logic [N_REQ-1:0]          req_ready,
  output logic                      WE_C,
  output logic [ADDR_W-1:0]         DirC,
  output logic [DATA_W-1:0]         DinC,
  output logic                      WE_V,
  output logic [ADDR_W-1:0]         DirV,
  output logic [DATA_W-1:0]         DinV,
  output logic                      conflict
);

  localparam int               PTR_W    = $clog2(N_REQ);
  localparam logic [PTR_W:0]   N_REQ_L  = (PTR_W+1)'(N_REQ);
  localparam logic [PTR_W-1:0] PTR_ZERO = PTR_W'(0);
  localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

  // (a + b) mod N_REQ for operands already inside 0..N_REQ-1
  function automatic logic [PTR_W-1:0] f_wrap_add(input logic [PTR_W-1:0] a,
                                                  input logic [PTR_W-1:0] b);
    logic [PTR_W:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= N_REQ_L) begin
      s = s - N_REQ_L;
    end else begin
      s = s;
    end
    return s[PTR_W-1:0];
  endfunction

  logic [PTR_W-1:0]  r_ptr;
  logic [PTR_W-1:0]  w_ptr_nxt;
  logic [PTR_W-1:0]  w_idx;
  logic [PTR_W-1:0]  w_gc;
  logic [PTR_W-1:0]  w_gv;
  logic              w_found_c;
  logic              w_found_v;
  logic              w_defer;
  logic [ADDR_W-1:0] w_dir_c;
  logic [ADDR_W-1:0] w_dir_v;
  logic [DATA_W-1:0] w_din_c;
  logic [DATA_W-1:0] w_din_v;

  // Rotating scan from r_ptr: first valid -> port C, next valid with a different
  // register -> port V; same-register requesters seen before V is filled are deferred
  always_comb begin
    w_idx     = PTR_ZERO;
    w_gc      = PTR_ZERO;
    w_gv      = PTR_ZERO;
    w_found_c = 1'b0;
    w_found_v = 1'b0;
    w_defer   = 1'b0;
    for (int k = 0; k < N_REQ; k++) begin
      w_idx = f_wrap_add(r_ptr, PTR_W'(k));
      if (!stall && req_valid[w_idx]) begin
        if (!w_found_c) begin
          w_found_c = 1'b1;
          w_gc      = w_idx;
        end else if (!w_found_v) begin
          if (req_dir[w_idx*ADDR_W +: ADDR_W] != req_dir[w_gc*ADDR_W +: ADDR_W]) begin
            w_found_v = 1'b1;
            w_gv      = w_idx;
          end else begin
            w_defer = 1'b1;
          end
        end else begin
          // both ports taken: later requesters simply wait, no clash reported
          w_defer = w_defer;
        end
      end else begin
        w_defer = w_defer;
      end
    end
  end

  assign w_dir_c = req_dir[w_gc*ADDR_W +: ADDR_W];
  assign w_dir_v = req_dir[w_gv*ADDR_W +: ADDR_W];
  assign w_din_c = req_din[w_gc*DATA_W +: DATA_W];
  assign w_din_v = req_din[w_gv*DATA_W +: DATA_W];

  // Decode the two grant indices into the per-requester ready vector
  always_comb begin
    req_ready = {N_REQ{1'b0}};
    for (int i = 0; i < N_REQ; i++) begin
      if ((w_found_c && (w_gc == PTR_W'(i))) || (w_found_v && (w_gv == PTR_W'(i)))) begin
        req_ready[i] = 1'b1;
      end else begin
        req_ready[i] = 1'b0;
      end
    end
  end

  // Next pointer: one past the last index granted in scan order, else hold
  always_comb begin
    if (w_found_v) begin
      w_ptr_nxt = f_wrap_add(w_gv, PTR_ONE);
    end else if (w_found_c) begin
      w_ptr_nxt = f_wrap_add(w_gc, PTR_ONE);
    end else begin
      w_ptr_nxt = r_ptr;
    end
  end

  // Round-robin pointer register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_ptr <= PTR_ZERO;
    end else begin
      r_ptr <= w_ptr_nxt;
    end
  end

  // Bank port C register: enable follows the grant, address/data hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WE_C <= 1'b0;
      DirC <= {ADDR_W{1'b0}};
      DinC <= {DATA_W{1'b0}};
    end else begin
      WE_C <= w_found_c;
      if (w_found_c) begin
        DirC <= w_dir_c;
        DinC <= w_din_c;
      end else begin
        DirC <= DirC;
        DinC <= DinC;
      end
    end
  end

  // Bank port V register: enable follows the grant, address/data hold when idle
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      WE_V <= 1'b0;
      DirV <= {ADDR_W{1'b0}};
      DinV <= {DATA_W{1'b0}};
    end else begin
      WE_V <= w_found_v;
      if (w_found_v) begin
        DirV <= w_dir_v;
        DinV <= w_din_v;
      end else begin
        DirV <= DirV;
        DinV <= DinV;
      end
    end
  end

  // Address-clash pulse, one cycle after a requester was held back
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      conflict <= 1'b0;
    end else begin
      conflict <= w_defer;
    end
  end

endmodule

// File: tb/tb_banco_write_arbiter.sv
// Scoreboard bench for banco_write_arbiter: the stimulus side runs a
// list-based reference model and queues the expected ready vector and bank
// writes. Two monitors pop those entries and compare them with the DUT.
module tb_banco_write_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int AW = 4;

  logic            clk = 1'b0;
  logic            rst_n = 1'b1;
  logic            stall = 1'b0;
  logic [N-1:0]    req_valid = '0;
  logic [N*AW-1:0] req_dir = '0;
  logic [N*DW-1:0] req_din = '0;
  logic [N-1:0]    req_ready;
  logic            WE_C, WE_V, conflict;
  logic [AW-1:0]   DirC, DirV;
  logic [DW-1:0]   DinC, DinV;

  banco_write_arbiter #(.N_REQ(N), .DATA_W(DW), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n), .stall(stall),
    .req_valid(req_valid), .req_dir(req_dir), .req_din(req_din),
    .req_ready(req_ready),
    .WE_C(WE_C), .DirC(DirC), .DinC(DinC),
    .WE_V(WE_V), .DirV(DirV), .DinV(DinV),
    .conflict(conflict)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          we_c;
    logic [AW-1:0] dir_c;
    logic [DW-1:0] din_c;
    logic          we_v;
    logic [AW-1:0] dir_v;
    logic [DW-1:0] din_v;
    logic          conf;
  } out_t;

  out_t         q_out[$];
  logic [N-1:0] q_rdy[$];
  int n_tests = 0;
  int n_fail  = 0;

  // reference model state
  int            m_ptr = 0;
  logic [AW-1:0] m_dirc = '0, m_dirv = '0;
  logic [DW-1:0] m_dinc = '0, m_dinv = '0;

  // requester state for the random phase
  logic          p_valid[N];
  logic [AW-1:0] p_dir[N];
  logic [DW-1:0] p_din[N];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [AW-1:0] in_dir(input int i);
    return req_dir[i*AW +: AW];
  endfunction

  function automatic logic [DW-1:0] in_din(input int i);
    return req_din[i*DW +: DW];
  endfunction

  // Reference: list valid requesters in rotation order, take the first, then the
  // first later one aiming at another register; anything skipped in between clashed.
  task automatic model_step(output logic [N-1:0] rdy);
    int   order[$];
    int   gc, gv, pos;
    bit   fc, fv;
    out_t o;
    rdy = '0; fc = 0; fv = 0; gc = 0; gv = 0; pos = 0;
    o.conf = 1'b0;
    if (!stall) begin
      for (int k = 0; k < N; k++) begin
        if (req_valid[(m_ptr + k) % N]) order.push_back((m_ptr + k) % N);
      end
    end
    if (order.size() > 0) begin
      fc = 1; gc = order[0];
      for (int j = 1; j < order.size(); j++) begin
        if (!fv && in_dir(order[j]) != in_dir(gc)) begin
          fv = 1; gv = order[j]; pos = j;
        end
      end
      o.conf = fv ? (pos > 1) : (order.size() > 1);
    end
    if (fc) begin rdy[gc] = 1'b1; m_dirc = in_dir(gc); m_dinc = in_din(gc); end
    if (fv) begin rdy[gv] = 1'b1; m_dirv = in_dir(gv); m_dinv = in_din(gv); end
    if (fv) m_ptr = (gv + 1) % N;
    else if (fc) m_ptr = (gc + 1) % N;
    o.we_c = fc; o.dir_c = m_dirc; o.din_c = m_dinc;
    o.we_v = fv; o.dir_v = m_dirv; o.din_v = m_dinv;
    q_rdy.push_back(rdy);
    q_out.push_back(o);
  endtask

  task automatic cycle(input logic [N-1:0] v, input logic [N*AW-1:0] d,
                       input logic [N*DW-1:0] x, input logic st, output logic [N-1:0] rdy);
    @(negedge clk);
    req_valid = v; req_dir = d; req_din = x; stall = st;
    #1;
    model_step(rdy);
  endtask

  task automatic model_reset();
    m_ptr = 0; m_dirc = '0; m_dirv = '0; m_dinc = '0; m_dinv = '0;
    q_out.delete(); q_rdy.delete();
  endtask

  // Ready monitor: ready is combinational, checked mid-low-phase after inputs settle
  initial begin
    logic [N-1:0] e;
    forever begin
      @(negedge clk); #2;
      if (q_rdy.size() > 0) begin
        e = q_rdy.pop_front();
        check("req_ready", 64'(req_ready), 64'(e));
      end
    end
  end

  // Write-port monitor: registered outputs checked just after each rising edge
  initial begin
    out_t e;
    forever begin
      @(posedge clk); #1;
      if (q_out.size() > 0) begin
        e = q_out.pop_front();
        check("WE_C", 64'(WE_C), 64'(e.we_c));
        check("DirC", 64'(DirC), 64'(e.dir_c));
        check("DinC", 64'(DinC), 64'(e.din_c));
        check("WE_V", 64'(WE_V), 64'(e.we_v));
        check("DirV", 64'(DirV), 64'(e.dir_v));
        check("DinV", 64'(DinV), 64'(e.din_v));
        check("conflict", 64'(conflict), 64'(e.conf));
      end
    end
  end

  localparam logic [N*AW-1:0] DIRS_DISTINCT = {4'd12, 4'd8, 4'd5, 4'd1};
  localparam logic [N*DW-1:0] DINS_A = {32'd400, 32'd300, 32'd200, 32'd100};

  initial begin
    logic [N-1:0]    rdy;
    logic [N-1:0]    v;
    logic [N*AW-1:0] d;
    logic [N*DW-1:0] x;
    logic            st;

    // reset state
    #1 rst_n = 1'b0;
    #2;
    check("rst_WE_C", 64'(WE_C), 64'd0);
    check("rst_WE_V", 64'(WE_V), 64'd0);
    check("rst_conflict", 64'(conflict), 64'd0);
    check("rst_DirC", 64'(DirC), 64'd0);
    check("rst_DinV", 64'(DinV), 64'd0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;

    // reset while a write is on port C, then check order restarts at req 0
    cycle(4'b0001, {4'd0, 4'd0, 4'd0, 4'd9}, {96'd0, 32'd77}, 1'b0, rdy);
    @(posedge clk); #3;
    check("pre_rst_WE_C", 64'(WE_C), 64'd1);
    rst_n = 1'b0;
    #1;
    check("async_rst_WE_C", 64'(WE_C), 64'd0);
    check("async_rst_WE_V", 64'(WE_V), 64'd0);
    check("async_rst_conflict", 64'(conflict), 64'd0);
    model_reset();
    @(posedge clk); #3 rst_n = 1'b1;
    cycle(4'b1111, DIRS_DISTINCT, DINS_A, 1'b0, rdy);
    check("first_after_rst", 64'(req_ready), 64'h3);

    // two requests to R3 / R15 with ptr=0 (ptr is 2 now, realign first)
    cycle(4'b1100, DIRS_DISTINCT, DINS_A, 1'b0, rdy);
    cycle(4'b0011, {4'd0, 4'd0, 4'd15, 4'd3}, {32'd0, 32'd0, 32'd99, 32'd54}, 1'b0, rdy);
    check("two_req_ready", 64'(req_ready), 64'h3);
    cycle(4'b1100, DIRS_DISTINCT, DINS_A, 1'b0, rdy);

    // clash on R7 between req0 and req2
    cycle(4'b0101, {4'd0, 4'd7, 4'd0, 4'd7}, {32'd0, 32'd22, 32'd0, 32'd11}, 1'b0, rdy);
    check("clash_first", 64'(req_ready), 64'h1);
    cycle(4'b0100, {4'd0, 4'd7, 4'd0, 4'd7}, {32'd0, 32'd22, 32'd0, 32'd11}, 1'b0, rdy);
    check("clash_second", 64'(req_ready), 64'h4);

    // fairness with all requesters valid
    repeat (6) cycle(4'b1111, DIRS_DISTINCT, DINS_A, 1'b0, rdy);

    // stall for three cycles, then resume
    repeat (3) begin
      cycle(4'b0110, DIRS_DISTINCT, DINS_A, 1'b1, rdy);
      check("stall_ready", 64'(req_ready), 64'h0);
    end
    cycle(4'b0110, DIRS_DISTINCT, DINS_A, 1'b0, rdy);

    // reset in the middle of a burst
    repeat (3) cycle(4'b1111, DIRS_DISTINCT, DINS_A, 1'b0, rdy);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    check("burst_rst_WE_C", 64'(WE_C), 64'd0);
    check("burst_rst_WE_V", 64'(WE_V), 64'd0);
    model_reset();
    @(posedge clk); #3 rst_n = 1'b1;
    cycle(4'b1111, DIRS_DISTINCT, DINS_A, 1'b0, rdy);
    check("burst_restart", 64'(req_ready), 64'h3);

    // randomized traffic with a narrow address range to provoke clashes
    for (int i = 0; i < N; i++) p_valid[i] = 1'b0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < N; i++) begin
        if (!p_valid[i] && ($urandom_range(2) != 0)) begin
          p_valid[i] = 1'b1;
          p_dir[i]   = AW'($urandom_range(3));
          p_din[i]   = $urandom;
        end
        v[i] = p_valid[i];
        d[i*AW +: AW] = p_valid[i] ? p_dir[i] : AW'($urandom_range(15));
        x[i*DW +: DW] = p_valid[i] ? p_din[i] : DW'($urandom);
      end
      st = ($urandom_range(7) == 0);
      cycle(v, d, x, st, rdy);
      for (int i = 0; i < N; i++) if (rdy[i]) p_valid[i] = 1'b0;
    end

    // drain
    cycle('0, '0, '0, 1'b0, rdy);
    @(posedge clk); #3;
    check("scoreboard_drained", 64'(q_out.size() + q_rdy.size()), 64'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // global time bound so the run always ends
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time bound");
    n_fail++;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $fatal(1);
  end
endmodule
